// File: rtl/dsp_pkg.sv
// Shared encodings for the DSP multiply/MAC extension.
// Pure definitions, no logic and no latency.
// No flow control.
package dsp_pkg;

   // Operation select, as presented on the op port
   typedef enum logic [1:0] {
      OP_MUL   = 2'd0,
      OP_MAC   = 2'd1,
      OP_MULH  = 2'd2,
      OP_MULHU = 2'd3
   } dsp_op_t;

   // Engine sequencing states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WB   = 2'd2
   } dsp_state_t;

   // Dedicated DSP register indices in the register file
   localparam logic [4:0] REG_A   = 5'd16;
   localparam logic [4:0] REG_B   = 5'd17;
   localparam logic [4:0] REG_ACC = 5'd18;

endpackage

// File: rtl/seq_mul32.sv
// 32x32 -> 64 radix-2 shift-add multiplier, optional signed-magnitude mode.
// Latency: 32 cycles after the start edge; last is high during the 32nd step.
// No backpressure: prod holds its final value until the next start.
module seq_mul32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        last,
   output logic [63:0] prod
);

   logic [63:0] mcand;
   logic [31:0] mplier;
   logic [63:0] acc;
   logic [4:0]  cnt;
   logic        neg;
   logic        active;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [63:0] sum;

   // Operand magnitudes and the partial-product accumulation for this step
   always_comb begin
      mag_a = (is_signed && a[31]) ? -a : a;
      mag_b = (is_signed && b[31]) ? -b : b;
      sum   = acc + (mplier[0] ? mcand : 64'd0);
   end

   // Shift-add datapath: one multiplier bit per cycle, sign fixed on the last step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         active <= 1'b0;
      end else if (start) begin
         mcand  <= {32'd0, mag_a};
         mplier <= mag_b;
         acc    <= '0;
         cnt    <= '0;
         neg    <= is_signed && (a[31] ^ b[31]);
         active <= 1'b1;
      end else if (active) begin
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 5'd1;
         if (cnt == 5'd31) begin
            active <= 1'b0;
            acc    <= neg ? -sum : sum;
         end else begin
            acc <= sum;
         end
      end
   end

   assign last = active && (cnt == 5'd31);
   assign prod = acc;

endmodule

// File: rtl/dsp_mac_writeback.sv
// DSP MUL/MAC/MULH/MULHU engine writing its result to the register file.
// Latency: 33 cycles start-to-write minimum (32 RUN + 1 WB), +1 per stalled cycle.
// Shares the write port with core writeback; core always wins, DSP waits in WB.
module dsp_mac_writeback
   import dsp_pkg::*;
#(
   parameter logic [4:0] RESULT_ADDR = REG_ACC,
   parameter int         XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] r16,
   input  logic [XLEN-1:0] r17,
   input  logic [XLEN-1:0] r18,
   input  logic            core_we,
   input  logic [4:0]      core_rd_addr,
   input  logic [XLEN-1:0] core_rd_data,
   output logic            write_en,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            busy,
   output logic            done
);

   dsp_state_t      state;
   dsp_op_t         op_q;
   logic [XLEN-1:0] r18_q;
   logic [XLEN-1:0] result;
   logic            mul_start;
   logic            mul_last;
   logic [63:0]     prod;

   // Multiplier only accepts while idle, so a start during busy is dropped
   assign mul_start = (state == S_IDLE) && start;

   seq_mul32 u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (mul_start),
      .is_signed (op == OP_MULH),
      .a         (r16),
      .b         (r17),
      .last      (mul_last),
      .prod      (prod)
   );

   // Result select from the latched op; stays stable while WB is stalled
   always_comb begin
      result = prod[31:0];
      case (op_q)
         OP_MUL:   result = prod[31:0];
         OP_MAC:   result = r18_q + prod[31:0];
         OP_MULH:  result = prod[63:32];
         OP_MULHU: result = prod[63:32];
         default:  result = prod[31:0];
      endcase
   end

   // Sequencer: accept, wait for the multiplier, then wait for a free write slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         op_q  <= OP_MUL;
         r18_q <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q  <= dsp_op_t'(op);
                  r18_q <= r18;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (mul_last) begin
                  state <= S_WB;
               end
            end
            S_WB: begin
               if (!core_we) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Write-port arbitration: core first, then a pending DSP result, else quiet
   always_comb begin
      write_en = 1'b0;
      rd_addr  = '0;
      rd_data  = '0;
      if (core_we) begin
         write_en = 1'b1;
         rd_addr  = core_rd_addr;
         rd_data  = core_rd_data;
      end else if (state == S_WB) begin
         write_en = 1'b1;
         rd_addr  = RESULT_ADDR;
         rd_data  = result;
      end
   end

endmodule

// File: tb/tb_dsp_mac_writeback.sv
// Self-checking bench for dsp_mac_writeback against an arithmetic reference.
// Cycle k is the period after the k-th rising edge following the start cycle.
// Core traffic is modelled as the exact write-port contents the DUT must show.
module tb_dsp_mac_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] r16, r17, r18;
   logic        core_we;
   logic [4:0]  core_rd_addr;
   logic [31:0] core_rd_data;
   logic        write_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dsp_mac_writeback dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .op           (op),
      .r16          (r16),
      .r17          (r17),
      .r18          (r18),
      .core_we      (core_we),
      .core_rd_addr (core_rd_addr),
      .core_rd_data (core_rd_data),
      .write_en     (write_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: full-width products computed with 64-bit arithmetic
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
      logic [63:0] pu;
      logic [63:0] ps;
      longint      sa, sb;
      pu = {32'd0, a} * {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ps = sa * sb;
      case (o)
         2'd0:    return pu[31:0];
         2'd1:    return c + pu[31:0];
         2'd2:    return ps[63:32];
         default: return pu[63:32];
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: core idle; 1: core writes in cycles p0..p1; 2: random core writes (1 in p0);
   // 3: core writes r16=100 in cycle p0. mid>0 pulses a (to be ignored) start in that cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input int mode, input int p0, input int p1,
                         input int mid);
      logic [31:0] exp_res;
      logic [37:0] exp_port;
      int          wcyc;
      logic        cw;
      exp_res = ref_result(o, a, b, c);
      wcyc    = -1;
      op = o; r16 = a; r17 = b; r18 = c; start = 1'b1;
      core_we = 1'b0; core_rd_addr = '0; core_rd_data = '0;
      for (int k = 1; k <= 300; k++) begin
         step();
         start = 1'b0;
         cw = 1'b0;
         core_rd_addr = 5'd5;
         core_rd_data = 32'hAA;
         case (mode)
            1: cw = (k >= p0) && (k <= p1);
            2: begin
               cw = ($urandom_range(p0 - 1, 0) == 0);
               core_rd_addr = 5'($urandom);
               core_rd_data = $urandom;
            end
            3: if (k == p0) begin
               cw = 1'b1;
               core_rd_addr = 5'd16;
               core_rd_data = 32'd100;
               r16 = 32'd100;
            end
            default: cw = 1'b0;
         endcase
         if (k == mid) begin
            start = 1'b1;
            op    = ~o;
            r17   = 32'd9;
            r18   = 32'h55;
         end
         core_we = cw;
         #1;
         if (wcyc < 0 && k >= 33 && !cw) wcyc = k;
         if (cw)             exp_port = {1'b1, core_rd_addr, core_rd_data};
         else if (k == wcyc) exp_port = {1'b1, 5'd18, exp_res};
         else                exp_port = '0;
         chk("wport", {write_en, rd_addr, rd_data}, exp_port);
         chk("busy", busy, (wcyc < 0) || (k <= wcyc));
         chk("done", done, (wcyc > 0) && (k == wcyc + 1));
         if (wcyc > 0 && k == wcyc + 1) break;
      end
      chk("wb_seen", wcyc > 0, 1'b1);
      start = 1'b0; core_we = 1'b0; core_rd_addr = '0; core_rd_data = '0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = '0; r16 = '0; r17 = '0; r18 = '0;
      core_we = 1'b1; core_rd_addr = 5'd3; core_rd_data = 32'h55;
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pass", {write_en, rd_addr, rd_data}, {1'b1, 5'd3, 32'h55});
      core_we = 1'b0; core_rd_addr = '0; core_rd_data = '0;
      #1;
      chk("rst_idle", {write_en, rd_addr, rd_data}, 38'd0);
      rst_n = 1'b1;
      step();

      // Directed cases
      run_op(2'd0, 32'd7, 32'd6, 32'd0, 0, 0, 0, 0);
      run_op(2'd1, 32'hFFFFFFFF, 32'd2, 32'd10, 0, 0, 0, 0);
      run_op(2'd3, 32'hFFFFFFFF, 32'd2, 32'd10, 0, 0, 0, 0);
      run_op(2'd2, 32'hFFFFFFFD, 32'd5, 32'd0, 0, 0, 0, 0);
      run_op(2'd3, 32'hFFFFFFFD, 32'd5, 32'd0, 0, 0, 0, 0);
      run_op(2'd0, 32'd3, 32'd4, 32'd0, 1, 33, 35, 12);
      run_op(2'd0, 32'd7, 32'd6, 32'd0, 3, 5, 0, 0);
      run_op(2'd2, 32'h80000000, 32'h80000000, 32'd0, 0, 0, 0, 0);
      run_op(2'd2, 32'h80000000, 32'd1, 32'd0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of RUN
      op = 2'd0; r16 = 32'd7; r17 = 32'd6; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 2; k <= 10; k++) step();
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_we", write_en, 1'b0);
      step();
      step();
      #2 rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         chk("abort_quiet", {write_en, done, busy}, 3'b000);
      end
      run_op(2'd0, 32'd7, 32'd6, 32'd0, 0, 0, 0, 0);

      // Randomized operations with random core traffic and stray starts
      for (int i = 0; i < 30; i++) begin
         run_op(2'($urandom_range(3, 0)), $urandom, $urandom, $urandom,
                ($urandom_range(1, 0) == 1) ? 2 : 0, 3, 0, $urandom_range(30, 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_mac_writeback.md
Name: dsp_mac_writeback

Overview:
- Iterative multiply/multiply-accumulate engine for the DSP extension.
- Reads the dedicated operand registers r16/r17/r18 exported by the register file.
- Computes a 64-bit product over 32 cycles.
- Writes the selected 32-bit result back through the register-file write port, which it shares with the core writeback path under fixed-priority arbitration (core first).

Parameters:
- RESULT_ADDR, 5'd18, destination register index for the DSP result.
- XLEN, 32, operand/result width. Only 32 is supported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE
- op  in  2  0=MUL (low 32), 1=MAC (r18 + low 32), 2=MULH (signed high 32), 3=MULHU (unsigned high 32)
- r16  in  32  operand A
- r17  in  32  operand B
- r18  in  32  accumulator input (MAC only)
- core_we  in  1  core writeback valid
- core_rd_addr  in  5  core writeback destination
- core_rd_data  in  32  core writeback data
- write_en  out  1  to register file write_en
- rd_addr  out  5  to register file rd_addr
- rd_data  out  32  to register file rd_data
- busy  out  1  high from accept through the DSP write cycle
- done  out  1  one-cycle pulse in the cycle after the DSP result write

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - busy=0, done=0.
  - All internal registers are cleared.
  - write_en/rd_addr/rd_data follow the core passthrough, so no DSP write is asserted.
- States: IDLE -> RUN -> WB -> IDLE.
- IDLE: on start=1, latch r16, r17, r18 and op at that clock edge, set cnt=0 and acc=0, go to RUN, and set busy=1 from the next cycle.
- RUN: radix-2 shift-add, one multiplier bit per cycle.
  - MULH: operate on magnitudes; the sign is XOR of the operand MSBs.
  - Exactly 32 RUN cycles. When cnt=31, apply sign negation (MULH only) and go to WB.
- Result select:
  - MUL: prod[31:0]
  - MAC: (r18_latched + prod[31:0]) mod 2^32, no saturation, no flags
  - MULH / MULHU: prod[63:32]
- WB: the DSP write is issued only in a cycle where core_we=0.
  - If core_we=1, hold in WB with the result kept stable.
  - There is no timeout.
  - The write cycle drives write_en=1, rd_addr=RESULT_ADDR, rd_data=result, then goes to IDLE. done=1 and busy=0 in the following cycle.
- Write-port mux (combinational): core_we=1 passes the core signals through. Otherwise, in WB, the DSP write is driven. Otherwise write_en=0 and rd_addr/rd_data are don't-care (drive 0).
- Minimum latency: start edge to DSP write cycle = 33 cycles (32 RUN + 1 WB). Each stalled cycle adds 1.
- start while busy: ignored, with no queuing.
- Core writes to r16/r17/r18 during RUN/WB do not affect the running operation, because operands were latched at accept.
- Core write to RESULT_ADDR in the same cycle as a pending WB: the core write happens first and the DSP write follows in the next free cycle. The DSP value is therefore final.
- Core writes with rd_addr=0 pass through unchanged; the register file discards them.
- Reset mid-RUN/WB: the operation is aborted with no DSP write and no done pulse.

Decomposition:
- Shared package dsp_pkg:
  - op encodings (OP_MUL, OP_MAC, OP_MULH, OP_MULHU)
  - state encoding (S_IDLE, S_RUN, S_WB)
  - DSP register indices 16/17/18
- One natural sub-module: seq_mul32, the 32-cycle shift-add core with start/valid and signed-magnitude handling.
- The FSM, MAC add and write-port mux stay in the top.

Test Plan:
- r16=7, r17=6, op=MUL, start; core idle -> write_en at cycle 33 with rd_addr=18, rd_data=42; done at cycle 34.
- r16=0xFFFFFFFF, r17=2, r18=10, op=MAC -> rd_data=0x00000008 (wrap); op=MULHU same operands -> rd_data=0x00000001.
- r16=-3 (0xFFFFFFFD), r17=5, op=MULH -> rd_data=0xFFFFFFFF; op=MULHU -> rd_data=0x00000004.
- MUL 3*4, core_we=1 (rd_addr=5, data=0xAA) for cycles 33-35 -> the core writes pass through on those cycles and the DSP write of 12 to x18 occurs at cycle 36. Also pulse start again mid-RUN -> ignored.
- Core writes r16=100 at cycle 5 of a 7*6 MUL -> result is still 42.
- Assert rst_n=0 asynchronously at RUN cycle 10 -> busy drops immediately, and after release there is no write_en/done; a new start afterwards completes normally.
